// File: rtl/cpu_wb_master.sv
// ---------------------------------------------------------------------------
// cpu_wb_master
//
// Bridges a CPU valid/ready load/store request onto a single Wishbone B4
// classic cycle and returns a one-cycle response pulse. Misaligned requests
// (address not word aligned, or no byte enabled) are answered locally with an
// error and never reach the bus. A slave that does not acknowledge within
// TIMEOUT_CYCLES strobe cycles is abandoned and an error is returned.
//
// Parameters:
//   TIMEOUT_CYCLES  strobe cycles allowed without ack (1..65535)
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   req_valid_i/ready_o   CPU request handshake
//   req_addr_i/wdata_i    byte address and store data
//   req_be_i, req_we_i    byte enables, 1 = store / 0 = load
//   rsp_valid_o           one-cycle response pulse
//   rsp_rdata_o           load data (0 for stores and errors)
//   rsp_err_o             misaligned access or bus timeout
//   wb_*_o / wb_*_i       Wishbone classic master interface
// ---------------------------------------------------------------------------
module cpu_wb_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  input  logic        req_we_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Last value of to_cnt during which the strobe may still be held.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        misaligned;

  assign misaligned = (req_addr_i[1:0] != 2'b00) || (req_be_i == 4'b0000);

  // State and output registers: every output comes straight from a flop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    to_cnt_d    = to_cnt_q;

    case (state_q)
      S_IDLE: begin
        // ready_q is still low on the first cycle after reset release, so
        // nothing is accepted until the bridge advertises readiness.
        ready_d = 1'b1;
        if (req_valid_i && ready_q) begin
          ready_d = 1'b0;
          if (misaligned) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d  = S_BUS;
            adr_d    = req_addr_i;
            dat_d    = req_wdata_i;
            sel_d    = req_be_i;
            we_d     = req_we_i;
            cyc_d    = 1'b1;
            stb_d    = 1'b1;
            to_cnt_d = '0;
          end
        end
      end

      S_BUS: begin
        ready_d  = 1'b0;
        to_cnt_d = to_cnt_q + 16'd1;
        // Ack is checked first so it wins over a coincident timeout.
        if (wb_ack_i || (to_cnt_q == TO_LAST)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !wb_ack_i;
          rsp_rdata_d = (wb_ack_i && !we_q) ? wb_dat_i : 32'h0;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = 4'h0;
        end
      end

      S_RESP: begin
        state_d     = S_IDLE;
        ready_d     = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;

endmodule
